// File: rtl/blob_stats.sv
// blob_stats: per-frame statistics of a binary foreground pixel stream.
//
// Accumulates the foreground pixel count, the bounding box and the x/y
// coordinate sums for each frame.  At frame close the totals are moved
// into holding registers and the accumulators restart.  Two parallel
// restoring dividers (one quotient bit per cycle) then produce the integer
// centroid.  One result set is published per frame.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   hcount_in, vcount_in  coordinates of pixel_in
//   pixel_in, valid_in    binary pixel (1 = foreground) and its qualifier
//   frame_done_in         single-cycle end-of-frame pulse
//   x_min_out..y_max_out  bounding box of the last published frame
//   count_out             foreground pixel count of the last published frame
//   x/y_centroid_out      floor(sum / count)
//   empty_out             last published frame had count < MIN_COUNT
//   result_valid_out      one-cycle pulse when the outputs update
//   busy_out              divider running
//   overrun_out           sticky: frame_done_in arrived while busy
module blob_stats #(
    parameter int HWIDTH    = 11,
    parameter int VWIDTH    = 10,
    parameter int MIN_COUNT = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [HWIDTH-1:0]         hcount_in,
    input  logic [VWIDTH-1:0]         vcount_in,
    input  logic                      pixel_in,
    input  logic                      valid_in,
    input  logic                      frame_done_in,
    output logic [HWIDTH-1:0]         x_min_out,
    output logic [HWIDTH-1:0]         x_max_out,
    output logic [VWIDTH-1:0]         y_min_out,
    output logic [VWIDTH-1:0]         y_max_out,
    output logic [HWIDTH+VWIDTH-1:0]  count_out,
    output logic [HWIDTH-1:0]         x_centroid_out,
    output logic [VWIDTH-1:0]         y_centroid_out,
    output logic                      empty_out,
    output logic                      result_valid_out,
    output logic                      busy_out,
    output logic                      overrun_out
);

    localparam int CW  = HWIDTH + VWIDTH;
    localparam int SXW = CW + HWIDTH;
    localparam int SYW = CW + VWIDTH;
    // Both dividers run for the same number of iterations; the narrower
    // dividend is zero-extended.
    localparam int DW  = (SXW > SYW) ? SXW : SYW;
    localparam int IW  = $clog2(DW);

    localparam logic [1:0] S_ACCUM   = 2'd0;
    localparam logic [1:0] S_DIVIDE  = 2'd1;
    localparam logic [1:0] S_PUBLISH = 2'd2;

    logic [1:0]        r_state;

    logic [CW-1:0]     r_count;
    logic [SXW-1:0]    r_sum_x;
    logic [SYW-1:0]    r_sum_y;
    logic [HWIDTH-1:0] r_x_min, r_x_max;
    logic [VWIDTH-1:0] r_y_min, r_y_max;

    logic [CW-1:0]     r_h_count;
    logic [HWIDTH-1:0] r_h_x_min, r_h_x_max;
    logic [VWIDTH-1:0] r_h_y_min, r_h_y_max;
    logic              r_h_empty;

    // Dividend registers double as quotient registers: dividend bits shift
    // out at the top while quotient bits shift in at the bottom.
    logic [DW-1:0]     r_qx, r_qy;
    logic [CW-1:0]     r_rx, r_ry;
    logic [IW-1:0]     r_iter;

    logic              w_hit;
    logic [CW-1:0]     w_count_nx;
    logic [SXW-1:0]    w_sum_x_nx;
    logic [SYW-1:0]    w_sum_y_nx;
    logic [HWIDTH-1:0] w_x_min_nx, w_x_max_nx;
    logic [VWIDTH-1:0] w_y_min_nx, w_y_max_nx;
    logic              w_empty_nx;

    logic [CW:0]       w_rx_sh, w_ry_sh;
    logic              w_rx_ge, w_ry_ge;
    logic [CW-1:0]     w_rx_nx, w_ry_nx;

    // Accumulator values including the current pixel; a pixel coincident
    // with frame_done_in therefore lands in the closing frame's snapshot.
    assign w_hit      = valid_in & pixel_in;
    assign w_count_nx = r_count + CW'(w_hit);
    assign w_sum_x_nx = r_sum_x + (w_hit ? SXW'(hcount_in) : '0);
    assign w_sum_y_nx = r_sum_y + (w_hit ? SYW'(vcount_in) : '0);
    assign w_x_min_nx = (w_hit && hcount_in < r_x_min) ? hcount_in : r_x_min;
    assign w_x_max_nx = (w_hit && hcount_in > r_x_max) ? hcount_in : r_x_max;
    assign w_y_min_nx = (w_hit && vcount_in < r_y_min) ? vcount_in : r_y_min;
    assign w_y_max_nx = (w_hit && vcount_in > r_y_max) ? vcount_in : r_y_max;
    assign w_empty_nx = (w_count_nx < CW'(MIN_COUNT));

    // Restoring division step: shift in the next dividend bit, subtract the
    // divisor when it fits.
    assign w_rx_sh = {r_rx, r_qx[DW-1]};
    assign w_ry_sh = {r_ry, r_qy[DW-1]};
    assign w_rx_ge = (w_rx_sh >= {1'b0, r_h_count});
    assign w_ry_ge = (w_ry_sh >= {1'b0, r_h_count});
    assign w_rx_nx = w_rx_ge ? CW'(w_rx_sh - {1'b0, r_h_count}) : w_rx_sh[CW-1:0];
    assign w_ry_nx = w_ry_ge ? CW'(w_ry_sh - {1'b0, r_h_count}) : w_ry_sh[CW-1:0];

    assign busy_out = (r_state == S_DIVIDE);

    // Accumulators run in every state; any frame_done_in restarts them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_count <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
        end else if (frame_done_in) begin
            r_count <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
        end else begin
            r_count <= w_count_nx;
            r_sum_x <= w_sum_x_nx;
            r_sum_y <= w_sum_y_nx;
            r_x_min <= w_x_min_nx;
            r_x_max <= w_x_max_nx;
            r_y_min <= w_y_min_nx;
            r_y_max <= w_y_max_nx;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state          <= S_ACCUM;
            r_h_count        <= '0;
            r_h_x_min        <= '0;
            r_h_x_max        <= '0;
            r_h_y_min        <= '0;
            r_h_y_max        <= '0;
            r_h_empty        <= 1'b0;
            r_qx             <= '0;
            r_qy             <= '0;
            r_rx             <= '0;
            r_ry             <= '0;
            r_iter           <= '0;
            x_min_out        <= '0;
            x_max_out        <= '0;
            y_min_out        <= '0;
            y_max_out        <= '0;
            count_out        <= '0;
            x_centroid_out   <= '0;
            y_centroid_out   <= '0;
            empty_out        <= 1'b0;
            result_valid_out <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            result_valid_out <= (r_state == S_PUBLISH);
            if (frame_done_in && r_state != S_ACCUM) begin
                overrun_out <= 1'b1;
            end
            case (r_state)
                S_ACCUM: begin
                    if (frame_done_in) begin
                        r_h_count <= w_count_nx;
                        r_h_x_min <= w_x_min_nx;
                        r_h_x_max <= w_x_max_nx;
                        r_h_y_min <= w_y_min_nx;
                        r_h_y_max <= w_y_max_nx;
                        r_h_empty <= w_empty_nx;
                        r_qx      <= DW'(w_sum_x_nx);
                        r_qy      <= DW'(w_sum_y_nx);
                        r_rx      <= '0;
                        r_ry      <= '0;
                        r_iter    <= '0;
                        r_state   <= w_empty_nx ? S_PUBLISH : S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_qx   <= {r_qx[DW-2:0], w_rx_ge};
                    r_qy   <= {r_qy[DW-2:0], w_ry_ge};
                    r_rx   <= w_rx_nx;
                    r_ry   <= w_ry_nx;
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == IW'(DW - 1)) begin
                        r_state <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    if (r_h_empty) begin
                        x_min_out      <= '0;
                        x_max_out      <= '0;
                        y_min_out      <= '0;
                        y_max_out      <= '0;
                        count_out      <= '0;
                        x_centroid_out <= '0;
                        y_centroid_out <= '0;
                        empty_out      <= 1'b1;
                    end else begin
                        x_min_out      <= r_h_x_min;
                        x_max_out      <= r_h_x_max;
                        y_min_out      <= r_h_y_min;
                        y_max_out      <= r_h_y_max;
                        count_out      <= r_h_count;
                        x_centroid_out <= r_qx[HWIDTH-1:0];
                        y_centroid_out <= r_qy[VWIDTH-1:0];
                        empty_out      <= 1'b0;
                    end
                    r_state <= S_ACCUM;
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_stats.sv
// tb_blob_stats: directed bench for blob_stats.
// Two instances share one stimulus stream: index 0 uses MIN_COUNT=1,
// index 1 the default MIN_COUNT=16.  A frame-level model predicts every
// output on every cycle; literal expectations pin the model's results.
module tb_blob_stats;

    localparam int HW = 11;
    localparam int VW = 10;
    localparam int MC [2] = '{1, 16};
    localparam int LAT_DIV = 33;

    logic          clk, rst, vld, pix, fd;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;

    logic [HW-1:0]    xmin_o [2];
    logic [HW-1:0]    xmax_o [2];
    logic [VW-1:0]    ymin_o [2];
    logic [VW-1:0]    ymax_o [2];
    logic [HW+VW-1:0] cnt_o  [2];
    logic [HW-1:0]    xc_o   [2];
    logic [VW-1:0]    yc_o   [2];
    logic             emp_o  [2];
    logic             rv_o   [2];
    logic             busy_o [2];
    logic             ovr_o  [2];

    blob_stats #(.HWIDTH(HW), .VWIDTH(VW), .MIN_COUNT(1)) u_dut_mc1 (
        .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
        .pixel_in(pix), .valid_in(vld), .frame_done_in(fd),
        .x_min_out(xmin_o[0]), .x_max_out(xmax_o[0]),
        .y_min_out(ymin_o[0]), .y_max_out(ymax_o[0]),
        .count_out(cnt_o[0]), .x_centroid_out(xc_o[0]), .y_centroid_out(yc_o[0]),
        .empty_out(emp_o[0]), .result_valid_out(rv_o[0]),
        .busy_out(busy_o[0]), .overrun_out(ovr_o[0])
    );

    blob_stats #(.HWIDTH(HW), .VWIDTH(VW), .MIN_COUNT(16)) u_dut_mc16 (
        .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
        .pixel_in(pix), .valid_in(vld), .frame_done_in(fd),
        .x_min_out(xmin_o[1]), .x_max_out(xmax_o[1]),
        .y_min_out(ymin_o[1]), .y_max_out(ymax_o[1]),
        .count_out(cnt_o[1]), .x_centroid_out(xc_o[1]), .y_centroid_out(yc_o[1]),
        .empty_out(emp_o[1]), .result_valid_out(rv_o[1]),
        .busy_out(busy_o[1]), .overrun_out(ovr_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- frame-level model ----------------
    typedef struct { int x; int y; } pt_t;
    typedef struct { int cnt; int xmin; int xmax; int ymin; int ymax; int xc; int yc; int emp; } res_t;

    pt_t  pq[$];
    res_t out_res  [2];
    res_t pend_res [2];
    int   pending  [2];
    int   left     [2];
    int   exp_rv   [2];
    int   exp_busy [2];
    int   exp_ovr  [2];

    function automatic res_t frame_result(input int mc);
        res_t   r;
        longint sx, sy;
        r  = '{default: 0};
        sx = 0;
        sy = 0;
        if (pq.size() < mc) begin
            r.emp = 1;
            return r;
        end
        r.cnt  = pq.size();
        r.xmin = pq[0].x; r.xmax = pq[0].x;
        r.ymin = pq[0].y; r.ymax = pq[0].y;
        foreach (pq[i]) begin
            sx += pq[i].x;
            sy += pq[i].y;
            if (pq[i].x < r.xmin) r.xmin = pq[i].x;
            if (pq[i].x > r.xmax) r.xmax = pq[i].x;
            if (pq[i].y < r.ymin) r.ymin = pq[i].y;
            if (pq[i].y > r.ymax) r.ymax = pq[i].y;
        end
        r.xc = int'(sx / r.cnt);
        r.yc = int'(sy / r.cnt);
        return r;
    endfunction

    initial begin
        pt_t p;
        int  wasp;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pq.delete();
                for (int k = 0; k < 2; k++) begin
                    out_res[k]  = '{default: 0};
                    pending[k]  = 0;
                    left[k]     = 0;
                    exp_rv[k]   = 0;
                    exp_busy[k] = 0;
                    exp_ovr[k]  = 0;
                end
            end else begin
                if (vld && pix) begin
                    p.x = int'(hc);
                    p.y = int'(vc);
                    pq.push_back(p);
                end
                for (int k = 0; k < 2; k++) begin
                    wasp      = pending[k];
                    exp_rv[k] = 0;
                    if (fd) begin
                        if (wasp != 0) exp_ovr[k] = 1;
                        else begin
                            pend_res[k] = frame_result(MC[k]);
                            pending[k]  = 1;
                            left[k]     = (pend_res[k].emp != 0) ? 1 : LAT_DIV;
                        end
                    end
                    if (wasp != 0) begin
                        left[k]--;
                        if (left[k] == 0) begin
                            out_res[k] = pend_res[k];
                            exp_rv[k]  = 1;
                            pending[k] = 0;
                        end
                    end
                    exp_busy[k] = (pending[k] != 0 && pend_res[k].emp == 0 && left[k] >= 2) ? 1 : 0;
                end
                if (fd) pq.delete();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("result_valid[%0d]", k), rv_o[k], exp_rv[k]);
                chk($sformatf("busy[%0d]", k), busy_o[k], exp_busy[k]);
                chk($sformatf("overrun[%0d]", k), ovr_o[k], exp_ovr[k]);
                chk($sformatf("count[%0d]", k), cnt_o[k], out_res[k].cnt);
                chk($sformatf("x_min[%0d]", k), xmin_o[k], out_res[k].xmin);
                chk($sformatf("x_max[%0d]", k), xmax_o[k], out_res[k].xmax);
                chk($sformatf("y_min[%0d]", k), ymin_o[k], out_res[k].ymin);
                chk($sformatf("y_max[%0d]", k), ymax_o[k], out_res[k].ymax);
                chk($sformatf("x_cent[%0d]", k), xc_o[k], out_res[k].xc);
                chk($sformatf("y_cent[%0d]", k), yc_o[k], out_res[k].yc);
                chk($sformatf("empty[%0d]", k), emp_o[k], out_res[k].emp);
            end
        end
    end

    // ---------------- stimulus ----------------
    res_t snap [2];
    int   lat  [2];
    int   seen [2];
    int   bsy  [2];

    task automatic idle();
        vld = 1'b0; pix = 1'b0; fd = 1'b0; hc = '0; vc = '0;
    endtask

    task automatic drive(input int x, input int y, input bit p, input bit v, input bit f);
        hc = HW'(x); vc = VW'(y); pix = p; vld = v; fd = f;
        @(posedge clk);
        #1;
    endtask

    // Runs n idle cycles, recording per instance the first result pulse
    // (edges counted after the last driven edge) and whether busy was seen.
    task automatic watch(input int n);
        for (int k = 0; k < 2; k++) begin
            seen[k] = 0; lat[k] = -1; bsy[k] = 0; snap[k] = '{default: 0};
        end
        for (int i = 1; i <= n; i++) begin
            idle();
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (busy_o[k]) bsy[k] = 1;
                if (seen[k] == 0 && rv_o[k]) begin
                    seen[k]      = 1;
                    lat[k]       = i;
                    snap[k].cnt  = int'(cnt_o[k]);
                    snap[k].xmin = int'(xmin_o[k]);
                    snap[k].xmax = int'(xmax_o[k]);
                    snap[k].ymin = int'(ymin_o[k]);
                    snap[k].ymax = int'(ymax_o[k]);
                    snap[k].xc   = int'(xc_o[k]);
                    snap[k].yc   = int'(yc_o[k]);
                    snap[k].emp  = int'(emp_o[k]);
                end
            end
        end
    endtask

    task automatic chk_res(input string t, input int k, input int c, input int x0, input int x1,
                           input int y0, input int y1, input int xc, input int yc, input int e,
                           input int l);
        chk($sformatf("%s.lat[%0d]", t, k), lat[k], l);
        chk($sformatf("%s.count[%0d]", t, k), snap[k].cnt, c);
        chk($sformatf("%s.x_min[%0d]", t, k), snap[k].xmin, x0);
        chk($sformatf("%s.x_max[%0d]", t, k), snap[k].xmax, x1);
        chk($sformatf("%s.y_min[%0d]", t, k), snap[k].ymin, y0);
        chk($sformatf("%s.y_max[%0d]", t, k), snap[k].ymax, y1);
        chk($sformatf("%s.x_cent[%0d]", t, k), snap[k].xc, xc);
        chk($sformatf("%s.y_cent[%0d]", t, k), snap[k].yc, yc);
        chk($sformatf("%s.empty[%0d]", t, k), snap[k].emp, e);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset.count[%0d]", k), cnt_o[k], 0);
            chk($sformatf("reset.busy[%0d]", k), busy_o[k], 0);
            chk($sformatf("reset.overrun[%0d]", k), ovr_o[k], 0);
        end

        // single pixel at (100,50)
        drive(100, 50, 1, 1, 0);
        drive(0, 0, 0, 0, 1);
        watch(40);
        chk_res("single", 0, 1, 100, 100, 50, 50, 100, 50, 0, 33);
        chk_res("single", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("single.busy_seen[1]", bsy[1], 0);

        // 10x4 block inside a 20x8 raster of background pixels
        for (int y = 298; y <= 305; y++)
            for (int x = 195; x <= 214; x++)
                drive(x, y, (x >= 200 && x <= 209 && y >= 300 && y <= 303), 1, 0);
        drive(0, 0, 0, 0, 1);
        watch(40);
        for (int k = 0; k < 2; k++) chk_res("block", k, 40, 200, 209, 300, 303, 204, 301, 0, 33);

        // five pixels: below MIN_COUNT=16, above MIN_COUNT=1
        drive(10, 20, 1, 1, 0);
        drive(11, 20, 1, 1, 0);
        drive(30, 40, 1, 1, 0);
        drive(7, 9, 1, 1, 0);
        drive(500, 600, 1, 1, 0);
        drive(0, 0, 0, 0, 1);
        watch(40);
        chk_res("five", 0, 5, 7, 500, 9, 600, 111, 137, 0, 33);
        chk_res("five", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("five.busy_seen[1]", bsy[1], 0);

        // overrun: second frame_done 10 cycles into the division
        for (int i = 0; i < 20; i++) drive(1000 + i, 500 + i, 1, 1, 0);
        drive(0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) drive(2000, 1000, 1, 1, 0);
        drive(2000, 1000, 1, 1, 1);
        watch(30);
        for (int k = 0; k < 2; k++) begin
            chk_res("ovr", k, 20, 1000, 1019, 500, 519, 1009, 509, 0, 23);
            chk($sformatf("ovr.sticky[%0d]", k), ovr_o[k], 1);
        end
        for (int i = 0; i < 16; i++) drive(3 + i, 4, 1, 1, 0);
        drive(0, 0, 0, 0, 1);
        watch(40);
        for (int k = 0; k < 2; k++) begin
            chk_res("after_ovr", k, 16, 3, 18, 4, 4, 10, 4, 0, 33);
            chk($sformatf("after_ovr.sticky[%0d]", k), ovr_o[k], 1);
        end

        // reset 15 cycles into the division
        for (int i = 0; i < 16; i++) drive(50, 60 + i, 1, 1, 0);
        drive(0, 0, 0, 0, 1);
        repeat (15) drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst.count[%0d]", k), cnt_o[k], 0);
            chk($sformatf("midrst.x_min[%0d]", k), xmin_o[k], 0);
            chk($sformatf("midrst.busy[%0d]", k), busy_o[k], 0);
            chk($sformatf("midrst.overrun[%0d]", k), ovr_o[k], 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        watch(40);
        for (int k = 0; k < 2; k++) chk($sformatf("midrst.no_result[%0d]", k), seen[k], 0);

        // invalid foreground pixels ignored; pixel on frame_done included
        for (int i = 0; i < 16; i++) begin
            drive(40 + i, 70, 1, 1, 0);
            if (i % 4 == 0) drive(2047, 1023, 1, 0, 0);
            if (i % 4 == 2) drive(0, 0, 1, 0, 0);
        end
        drive(5, 7, 1, 1, 1);
        watch(40);
        for (int k = 0; k < 2; k++) chk_res("coincident", k, 17, 5, 55, 7, 70, 45, 66, 0, 33);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
